// File: rtl/out_pkg.sv
// Shared constants for the output-bus arbiter: FSM state encoding and size defaults.
package out_pkg;

    localparam int W_DEFAULT = 4;
    localparam int NREQ_MAX  = 4;

    // 2'b11 is unused and recovers to IDLE
    localparam logic [1:0] IDLE = 2'b00;
    localparam logic [1:0] LOAD = 2'b01;
    localparam logic [1:0] HOLD = 2'b10;

endpackage

// File: rtl/out_arb_pick.sv
// Combinational winner selection: round-robin from ptr_i when RR_EN=1,
// otherwise fixed priority with requester 0 highest (ptr_i ignored).
module out_arb_pick
    import out_pkg::*;
#(
    parameter int NREQ  = NREQ_MAX,
    parameter int PW    = 2,
    parameter bit RR_EN = 1'b0
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [PW-1:0]   ptr_i,
    output logic [NREQ-1:0] grant_o,
    output logic            valid_o
);

    int  base;
    logic found;

    // Walk the requesters starting at base; the first asserted one wins.
    always_comb begin
        grant_o = '0;
        found   = 1'b0;
        base    = RR_EN ? int'(ptr_i) : 0;
        for (int off = 0; off < NREQ; off++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (((base + off) % NREQ) == i && req_i[i] && !found) begin
                    grant_o[i] = 1'b1;
                    found      = 1'b1;
                end
            end
        end
        valid_o = found;
    end

endmodule

// File: rtl/out_bus_arbiter.sv
// Arbitrates requesters onto the output-register bus: IDLE -> LOAD -> HOLD per transfer.
// Define OUTARB_RR_EN for round-robin arbitration; default build is fixed priority.
module out_bus_arbiter
    import out_pkg::*;
#(
    parameter int NREQ = NREQ_MAX,
    parameter int W    = W_DEFAULT
) (
    input  logic              MainClock,
    input  logic              MainReset,
    input  logic [NREQ-1:0]   Req,
    input  logic [NREQ*W-1:0] ReqData,
    output logic [NREQ-1:0]   Grant,
    output logic [NREQ-1:0]   Ack,
    output logic [W-1:0]      IB,
    output logic              LoadOut,
    output logic              Busy
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
`ifdef OUTARB_RR_EN
    localparam bit RR_EN = 1'b1;
`else
    localparam bit RR_EN = 1'b0;
`endif

    logic [1:0]      state_q, state_d;
    logic [NREQ-1:0] grant_q, grant_d;
    logic [NREQ-1:0] ack_q,   ack_d;
    logic [W-1:0]    ib_q,    ib_d;
    logic            load_q,  load_d;

    logic [NREQ-1:0] winOneHot;
    logic            winValid;
    logic [W-1:0]    selData;
    logic [PW-1:0]   rrPtr;

`ifdef OUTARB_RR_EN
    logic [PW-1:0] ptr_q, ptr_d;
    logic [PW-1:0] winIdx;

    always_comb begin
        winIdx = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (winOneHot[i]) winIdx = PW'(i);
        end
    end

    // Pointer moves past the winner only when a grant is actually issued.
    always_comb begin
        ptr_d = ptr_q;
        if (state_q == IDLE && winValid) ptr_d = PW'((int'(winIdx) + 1) % NREQ);
    end

    always_ff @(posedge MainClock or posedge MainReset) begin
        if (MainReset) ptr_q <= '0;
        else           ptr_q <= ptr_d;
    end

    assign rrPtr = ptr_q;
`else
    assign rrPtr = '0;
`endif

    out_arb_pick #(
        .NREQ  (NREQ),
        .PW    (PW),
        .RR_EN (RR_EN)
    ) u_pick (
        .req_i   (Req),
        .ptr_i   (rrPtr),
        .grant_o (winOneHot),
        .valid_o (winValid)
    );

    always_comb begin
        selData = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (winOneHot[i]) selData = selData | ReqData[i*W +: W];
        end
    end

    // Data is latched on entry to LOAD so later ReqData changes never reach IB.
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        ib_d    = ib_q;
        load_d  = 1'b0;
        ack_d   = '0;
        case (state_q)
            IDLE: begin
                grant_d = '0;
                ib_d    = '0;
                if (winValid) begin
                    state_d = LOAD;
                    grant_d = winOneHot;
                    ib_d    = selData;
                    load_d  = 1'b1;
                end
            end
            LOAD: begin
                state_d = HOLD;
                ack_d   = grant_q;
            end
            HOLD: begin
                state_d = IDLE;
                grant_d = '0;
                ib_d    = '0;
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
                ib_d    = '0;
            end
        endcase
    end

    always_ff @(posedge MainClock or posedge MainReset) begin
        if (MainReset) begin
            state_q <= IDLE;
            grant_q <= '0;
            ack_q   <= '0;
            ib_q    <= '0;
            load_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            ack_q   <= ack_d;
            ib_q    <= ib_d;
            load_q  <= load_d;
        end
    end

    assign Grant   = grant_q;
    assign Ack     = ack_q;
    assign IB      = ib_q;
    assign LoadOut = load_q;
    assign Busy    = (state_q != IDLE);

endmodule
